// File: rtl/arf_pkg.sv
// Shared constants for the architectural register file and its writeback path.
package arf_pkg;
    localparam int XLEN         = 64;
    localparam int ARF_NREG     = 32;
    localparam int ARF_IDX_W    = $clog2(ARF_NREG);
    localparam int ARF_WB_PORTS = 4;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/arf_wb_rr_pick.sv
// Combinational round-robin scan: grants requesters, assigns write ports in
// scan order and computes the pointer for the following cycle.
module arf_wb_rr_pick import arf_pkg::*; #(
    parameter int N_REQ = 6,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ARF_IDX_W-1:0]    req_idx,
    input  logic [PTR_W-1:0]              rr_ptr,
    output logic [N_REQ-1:0]              req_ready,
    output logic [ARF_WB_PORTS*PTR_W-1:0] port_sel,
    output logic [ARF_WB_PORTS-1:0]       port_vld,
    output logic [PTR_W-1:0]              rr_ptr_next
);
    logic [ARF_IDX_W-1:0] alloc_idx [ARF_WB_PORTS];
    logic [2:0]           alloc_cnt;
    logic [ARF_IDX_W-1:0] cur_idx;
    logic                 dup;
    int                   cur;

    always_comb begin
        req_ready   = '0;
        port_sel    = '0;
        port_vld    = '0;
        rr_ptr_next = rr_ptr;
        alloc_cnt   = '0;
        cur_idx     = '0;
        dup         = 1'b0;
        cur         = 0;
        for (int k = 0; k < ARF_WB_PORTS; k++) alloc_idx[k] = '0;

        for (int j = 0; j < N_REQ; j++) begin
            cur = int'(rr_ptr) + j;
            if (cur >= N_REQ) cur = cur - N_REQ;
            cur_idx = req_idx[cur*ARF_IDX_W +: ARF_IDX_W];
            dup = 1'b0;
            for (int k = 0; k < ARF_WB_PORTS; k++) begin
                if (port_vld[k] && alloc_idx[k] == cur_idx) dup = 1'b1;
            end
            if (req_valid[cur]) begin
                // x0 results are dropped on the floor: accepted, no port used.
                if (cur_idx == '0) begin
                    req_ready[cur] = 1'b1;
                end else if (alloc_cnt < 3'd4 && !dup) begin
                    req_ready[cur]                          = 1'b1;
                    port_vld[alloc_cnt[1:0]]                = 1'b1;
                    port_sel[alloc_cnt[1:0]*PTR_W +: PTR_W] = PTR_W'(cur);
                    alloc_idx[alloc_cnt[1:0]]               = cur_idx;
                    alloc_cnt                               = alloc_cnt + 3'd1;
                    rr_ptr_next                             = PTR_W'(wrap_inc(cur, N_REQ));
                end
            end
        end
    end
endmodule

// File: rtl/arf_wb_arbiter.sv
// Writeback arbiter: schedules up to four completed results per cycle onto the
// register file write ports, round-robin, never duplicating a target register.
module arf_wb_arbiter import arf_pkg::*; #(
    parameter int N_REQ  = 6,
    parameter int N_PORT = 4,
    parameter int XLEN   = arf_pkg::XLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*5-1:0]     req_idx,
    input  logic [N_REQ*XLEN-1:0]  req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [4:0]             wb_idx_0,
    output logic [4:0]             wb_idx_1,
    output logic [4:0]             wb_idx_2,
    output logic [4:0]             wb_idx_3,
    output logic [XLEN-1:0]        wb_data_0,
    output logic [XLEN-1:0]        wb_data_1,
    output logic [XLEN-1:0]        wb_data_2,
    output logic [XLEN-1:0]        wb_data_3,
    output logic                   wb_en_0,
    output logic                   wb_en_1,
    output logic                   wb_en_2,
    output logic                   wb_en_3,
    output logic [15:0]            stall_cnt
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NP    = N_PORT;

    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     rr_ptr_next;
    logic [N_REQ-1:0]     pick_ready;
    logic [NP*PTR_W-1:0]  port_sel;
    logic [NP-1:0]        port_vld;
    logic [ARF_IDX_W-1:0] wb_idx_reg  [NP];
    logic [XLEN-1:0]      wb_data_reg [NP];
    logic [NP-1:0]        wb_en_reg;
    logic [15:0]          stall_cnt_reg;
    logic                 stall_now;

    arf_wb_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_valid   (req_valid),
        .req_idx     (req_idx),
        .rr_ptr      (rr_ptr_reg),
        .req_ready   (pick_ready),
        .port_sel    (port_sel),
        .port_vld    (port_vld),
        .rr_ptr_next (rr_ptr_next)
    );

    // Nothing may be granted while reset is held, or the result would be lost.
    assign req_ready = rst_n ? pick_ready : '0;
    assign stall_now = |(req_valid & ~req_ready);

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_port
            logic [PTR_W-1:0] sel;
            assign sel = port_sel[gi*PTR_W +: PTR_W];

            // Idle ports must carry idx 0 and data 0: the file writes x0 from them.
            always_ff @(posedge clk) begin
                if (!rst_n || !port_vld[gi]) begin
                    wb_en_reg[gi]   <= 1'b0;
                    wb_idx_reg[gi]  <= '0;
                    wb_data_reg[gi] <= '0;
                end else begin
                    wb_en_reg[gi]   <= 1'b1;
                    wb_idx_reg[gi]  <= req_idx[sel*ARF_IDX_W +: ARF_IDX_W];
                    wb_data_reg[gi] <= req_data[sel*XLEN +: XLEN];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (stall_now && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign wb_idx_0  = wb_idx_reg[0];
    assign wb_idx_1  = wb_idx_reg[1];
    assign wb_idx_2  = wb_idx_reg[2];
    assign wb_idx_3  = wb_idx_reg[3];
    assign wb_data_0 = wb_data_reg[0];
    assign wb_data_1 = wb_data_reg[1];
    assign wb_data_2 = wb_data_reg[2];
    assign wb_data_3 = wb_data_reg[3];
    assign wb_en_0   = wb_en_reg[0];
    assign wb_en_1   = wb_en_reg[1];
    assign wb_en_2   = wb_en_reg[2];
    assign wb_en_3   = wb_en_reg[3];
    assign stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_arf_wb_arbiter.sv
// Directed bench for arf_wb_arbiter with a small register file model fed by wb_*.
module tb_arf_wb_arbiter;
    localparam int N_REQ = 6;
    localparam int XLEN  = 64;

    logic                  clk;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*5-1:0]    req_idx;
    logic [N_REQ*XLEN-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic [4:0]            wb_idx  [4];
    logic [XLEN-1:0]       wb_data [4];
    logic                  wb_en   [4];
    logic [15:0]           stall_cnt;

    logic [XLEN-1:0] rf [32];
    int total = 0;
    int bad   = 0;
    int wait_c [N_REQ];
    int max_wait;

    arf_wb_arbiter #(.N_REQ(N_REQ), .N_PORT(4), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_idx_0  (wb_idx[0]),
        .wb_idx_1  (wb_idx[1]),
        .wb_idx_2  (wb_idx[2]),
        .wb_idx_3  (wb_idx[3]),
        .wb_data_0 (wb_data[0]),
        .wb_data_1 (wb_data[1]),
        .wb_data_2 (wb_data[2]),
        .wb_data_3 (wb_data[3]),
        .wb_en_0   (wb_en[0]),
        .wb_en_1   (wb_en[1]),
        .wb_en_2   (wb_en[2]),
        .wb_en_3   (wb_en[3]),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model; an idx-0 port overwrites x0 exactly like the real file.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (wb_en[p]) rf[wb_idx[p]] <= wb_data[p];
                if (wb_idx[p] == 5'd0) rf[0] <= wb_data[p];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input int p, input logic en,
                            input logic [4:0] idx, input logic [63:0] data);
        chk($sformatf("%s_p%0d_en", tag, p), 64'(wb_en[p]), 64'(en));
        chk($sformatf("%s_p%0d_idx", tag, p), 64'(wb_idx[p]), 64'(idx));
        chk($sformatf("%s_p%0d_data", tag, p), wb_data[p], data);
    endtask

    task automatic set_req(input int i, input logic [4:0] idx, input logic [63:0] d);
        req_valid[i]         = 1'b1;
        req_idx[i*5 +: 5]    = idx;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_idx   = '0;
        req_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_req();
        for (int i = 0; i < N_REQ; i++) set_req(i, 5'(i + 1), 64'hC0 + 64'(i));

        // Reset held 3 cycles with every requester valid
        repeat (3) tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        for (int p = 0; p < 4; p++) chk_port("rst", p, 1'b0, 5'd0, 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        chk("rst_ptr", 64'(dut.rr_ptr_reg), 64'h0);
        $display("reset: ready=%b stall=%0d", req_ready, stall_cnt);
        rst_n = 1'b1;
        clear_req();
        tick();

        // Four distinct requests
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 64'hA1 + 64'(i));
        #1;
        chk("t1_ready", 64'(req_ready), 64'b001111);
        tick();
        for (int p = 0; p < 4; p++) chk_port("t1", p, 1'b1, 5'(p + 1), 64'hA1 + 64'(p));
        chk("t1_ptr", 64'(dut.rr_ptr_reg), 64'd4);
        clear_req();
        tick();
        chk("t1_x3", rf[3], 64'hA3);
        $display("four distinct: x3=%h ptr=%0d", rf[3], dut.rr_ptr_reg);

        // Move the pointer back to 0 through requester 5
        set_req(5, 5'd9, 64'h99);
        #1;
        chk("fix_ready", 64'(req_ready), 64'b100000);
        tick();
        chk("fix_ptr", 64'(dut.rr_ptr_reg), 64'd0);
        clear_req();

        // Six requests, only four ports
        for (int i = 0; i < N_REQ; i++) set_req(i, 5'(i + 1), 64'hB0 + 64'(i));
        #1;
        chk("t2_ready_c", 64'(req_ready), 64'b001111);
        tick();
        chk("t2_stall", 64'(stall_cnt), 64'd1);
        chk("t2_ptr_c", 64'(dut.rr_ptr_reg), 64'd4);
        for (int p = 0; p < 4; p++) chk_port("t2c", p, 1'b1, 5'(p + 1), 64'hB0 + 64'(p));
        req_valid[3:0] = 4'b0000;
        #1;
        chk("t2_ready_c1", 64'(req_ready), 64'b110000);
        tick();
        chk_port("t2c1", 0, 1'b1, 5'd5, 64'hB4);
        chk_port("t2c1", 1, 1'b1, 5'd6, 64'hB5);
        chk_port("t2c1", 2, 1'b0, 5'd0, 64'h0);
        chk("t2_ptr_c1", 64'(dut.rr_ptr_reg), 64'd0);
        chk("t2_stall_c1", 64'(stall_cnt), 64'd1);
        clear_req();
        $display("six requests: stall=%0d ptr=%0d", stall_cnt, dut.rr_ptr_reg);

        // Same-idx conflict
        set_req(1, 5'd7, 64'h11);
        set_req(2, 5'd7, 64'h22);
        #1;
        chk("t3_ready_c", 64'(req_ready), 64'b000010);
        tick();
        chk_port("t3c", 0, 1'b1, 5'd7, 64'h11);
        chk_port("t3c", 1, 1'b0, 5'd0, 64'h0);
        chk("t3_stall", 64'(stall_cnt), 64'd2);
        chk("t3_ptr_c", 64'(dut.rr_ptr_reg), 64'd2);
        req_valid[1] = 1'b0;
        #1;
        chk("t3_ready_c1", 64'(req_ready), 64'b000100);
        tick();
        chk_port("t3c1", 0, 1'b1, 5'd7, 64'h22);
        chk("t3_ptr_c1", 64'(dut.rr_ptr_reg), 64'd3);
        clear_req();
        tick();
        chk("t3_x7", rf[7], 64'h22);
        $display("conflict: x7=%h", rf[7]);

        // x0 request alongside a real one (pointer is 3)
        set_req(0, 5'd0, 64'hFF);
        set_req(1, 5'd5, 64'h55);
        #1;
        chk("t4_ready", 64'(req_ready), 64'b000011);
        tick();
        chk_port("t4", 0, 1'b1, 5'd5, 64'h55);
        for (int p = 1; p < 4; p++) chk_port("t4", p, 1'b0, 5'd0, 64'h0);
        chk("t4_ptr", 64'(dut.rr_ptr_reg), 64'd2);
        clear_req();
        tick();
        chk("t4_x0", rf[0], 64'h0);
        chk("t4_x5", rf[5], 64'h55);
        $display("x0 handling: x0=%h x5=%h", rf[0], rf[5]);

        // Everybody targets x0
        for (int i = 0; i < N_REQ; i++) set_req(i, 5'd0, 64'hD0 + 64'(i));
        #1;
        chk("t5_ready", 64'(req_ready), 64'b111111);
        tick();
        chk_port("t5", 0, 1'b0, 5'd0, 64'h0);
        chk("t5_ptr", 64'(dut.rr_ptr_reg), 64'd2);
        chk("t5_stall", 64'(stall_cnt), 64'd2);
        clear_req();
        $display("all x0: ptr=%0d", dut.rr_ptr_reg);

        // Reset mid-operation discards in-flight writes; requester retries
        set_req(0, 5'd10, 64'hAA);
        tick();
        chk_port("t6pre", 0, 1'b1, 5'd10, 64'hAA);
        rst_n = 1'b0;
        #1;
        chk("t6_ready_rst", 64'(req_ready), 64'h0);
        tick();
        chk_port("t6rst", 0, 1'b0, 5'd0, 64'h0);
        chk("t6_ptr_rst", 64'(dut.rr_ptr_reg), 64'd0);
        chk("t6_stall_rst", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_ready_rel", 64'(req_ready), 64'b000001);
        tick();
        chk_port("t6post", 0, 1'b1, 5'd10, 64'hAA);
        chk("t6_ptr_post", 64'(dut.rr_ptr_reg), 64'd1);
        clear_req();
        $display("mid reset: ptr=%0d stall=%0d", dut.rr_ptr_reg, stall_cnt);

        // Continuous full load with repeated targets: saturation and fairness
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 5'((i % 3) + 1), 64'hE0 + 64'(i));
            wait_c[i] = 0;
        end
        max_wait = 0;
        for (int c = 0; c < 70000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && !req_ready[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
            tick();
        end
        chk("sat_stall", 64'(stall_cnt), 64'hFFFF);
        chk("starve_max_wait_ok", 64'(max_wait <= N_REQ), 64'd1);
        tick();
        chk("sat_hold", 64'(stall_cnt), 64'hFFFF);
        $display("full load: stall=%h max_wait=%0d", stall_cnt, max_wait);
        clear_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arf_wb_arbiter.md
# arf_wb_arbiter

Writeback arbiter for the 64-bit, 32-entry architectural register file. It collects completed results from N_REQ functional units over valid/ready handshakes and schedules up to four of them per cycle onto the register file's four write ports. Scheduling is round-robin. It never drives the same non-zero register index on two ports in one cycle, and keeps x0 at zero. It sits between the execution units and the register file write ports.

## Interface
- N_REQ, 6, number of result requesters (2..8)
- N_PORT, 4, register file write ports (fixed at 4)
- XLEN, 64, data width
- clk  in  1  clock
- rst_n  in  1  reset rst_n, synchronous, active-low; clock clk
- req_valid  in  N_REQ  requester i has a result
- req_idx  in  N_REQ*5  destination register index, requester i at bits [5i+4:5i]
- req_data  in  N_REQ*XLEN  result data, requester i at bits [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  N_REQ  request i accepted this cycle (combinational)
- wb_idx_0..3  out  5 each  write port index, registered
- wb_data_0..3  out  XLEN each  write port data, registered
- wb_en_0..3  out  1 each  write port enable, registered
- stall_cnt  out  16  saturating count of cycles with at least one valid request not accepted

## Operation
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high. The requester holds idx/data stable until the transfer. req_ready may depend on the current req_valid/req_idx of all requesters.
- Scan order: requesters are examined in order rr_ptr, rr_ptr+1, … mod N_REQ.
- x0 request (req_idx==0): always accepted. It consumes no port and causes no write.
- Non-x0 request: accepted if fewer than 4 ports are already allocated this cycle and its idx differs from every idx already allocated this cycle. Otherwise req_ready=0.
- Port mapping: the k-th accepted non-x0 request in scan order goes to port k (k=0..3). Unused ports are idle.
- Idle port drives wb_en=0, wb_idx=0, wb_data=0. This is mandatory: the register file writes x0 from any port whose idx is 0, so idle ports must carry zero data.
- rr_ptr update: if at least one non-x0 request is accepted, rr_ptr <= (index of last accepted non-x0 requester + 1) mod N_REQ. Otherwise it is unchanged.
- Same-idx conflict: only the first requester in scan order wins. The loser retries and is guaranteed to win within N_REQ cycles, because the pointer moves past the winner.
- stall_cnt increments by 1 in any cycle where some req_valid[i] is high with req_ready[i]=0. It saturates at 16'hFFFF.

## Timing
- Handshake in cycle C: wb_* for that request is valid during C+1. The register file updates at the end of C+1, and the value is readable on register file read ports in C+2.
- Throughput: up to 4 register writes per cycle, with no bubbles between cycles.
- Reset (rst_n=0 at a clk edge): wb_en_*=0, wb_idx_*=0, wb_data_*=0, rr_ptr=0, stall_cnt=0.
- While rst_n=0, req_ready=0 for all requesters, so no transfer is accepted during reset.
- Reset mid-operation: requests in flight on wb_* at the reset edge are discarded. Requesters that were not granted retry after reset.
- N_REQ ≤ 4 with all idx distinct and non-zero: every valid request is accepted every cycle.
- All requesters target x0: all are accepted, all ports stay idle, and rr_ptr is unchanged.

## Structure
- Shared package arf_pkg: XLEN, ARF_NREG=32, ARF_IDX_W=5, ARF_WB_PORTS=4.
- One sub-module, arf_wb_rr_pick: combinational scan that produces req_ready, the port allocation (requester id per port plus a valid bit), and next rr_ptr from req_valid, req_idx and rr_ptr.
- The top level holds rr_ptr, the wb_* output registers and stall_cnt.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1.
  - Required: req_ready=0, all wb_* = 0, stall_cnt=0.
- Four distinct requests: req0..3 with idx 1..4 and data 0xA1..0xA4, rr_ptr=0.
  - Required: all ready in C; in C+1, ports 0..3 show idx 1..4 with wb_en=1.
  - Required: rr_ptr=4 after the cycle, and register file read of x3 gives 0xA3 in C+2.
- Six requests: all six valid with idx 1..6 and rr_ptr=0.
  - Required in C: req0..3 accepted, req4/5 not ready, stall_cnt=1.
  - Required in C+1: req4/5 accepted on ports 0/1, rr_ptr ends at 0.
- Same-idx conflict: req1 and req2 both target idx 7 with data 0x11 and 0x22, rr_ptr=0.
  - Required in C: req1 wins, 0x11 is on port 0, and req2 stalls.
  - Required in C+1: req2 wins, and x7 finally holds 0x22.
- x0 handling: req0 has idx 0 with data 0xFF, req1 has idx 5.
  - Required: both ready, and only port 0 is active (idx 5).
  - Required: ports 1..3 show idx 0, data 0, and x0 reads 0 afterwards.
- Saturation/starvation: force 70000 cycles of one requester blocked.
  - Required: stall_cnt holds 0xFFFF.
  - Required: under continuous full load from all 6 requesters, no requester waits more than N_REQ cycles.
